// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key schedule controller: expands a 256-bit key into 15 round keys with one shared expansion step.
// Latency: key_valid rises 8 edges after the accepted start edge (counting that edge); reads return 1 cycle later.
// Backpressure: none; start is ignored while expanding, reads are accepted every cycle or rejected with rd_err.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, key          begin expansion of key (accepted in IDLE or DONE only)
//   rd_en, rd_idx       round-key read request, index 0..14
//   busy, key_valid     expansion in progress / all round keys stored
//   rd_valid, rd_key    registered read response (one-cycle pulse, held data)
//   rd_err              one-cycle pulse for a rejected read

// Single combinational key-expansion step.
// i_algorithm 2'b10 selects the AES-256 step (eight new words from eight old words);
// any other value performs an AES-128 step on the upper four words and passes the lower half through.
// i_step is the round-constant index (1 -> 8'h01, 2 -> 8'h02, ...).
module Key_Expansion_new (
    input  logic [1:0]   i_algorithm,
    input  logic [2:0]   i_step,
    input  logic [255:0] i_key,
    output logic [255:0] o_key
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    logic [31:0] w_in [8];
    logic [31:0] w_nw [8];
    logic [7:0]  w_rcon;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_in[k] = i_key[255 - 32*k -: 32];
        end
    end

    always_comb begin
        case (i_step)
            3'd1:    w_rcon = 8'h01;
            3'd2:    w_rcon = 8'h02;
            3'd3:    w_rcon = 8'h04;
            3'd4:    w_rcon = 8'h08;
            3'd5:    w_rcon = 8'h10;
            3'd6:    w_rcon = 8'h20;
            3'd7:    w_rcon = 8'h40;
            default: w_rcon = 8'h00;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_nw[k] = w_in[k];
        end
        if (i_algorithm == 2'b10) begin
            // AES-256: RotWord+SubWord+Rcon on the first new word, plain SubWord on the fifth.
            w_nw[0] = w_in[0] ^ sub_word(rot_word(w_in[7])) ^ {w_rcon, 24'h0};
            w_nw[1] = w_in[1] ^ w_nw[0];
            w_nw[2] = w_in[2] ^ w_nw[1];
            w_nw[3] = w_in[3] ^ w_nw[2];
            w_nw[4] = w_in[4] ^ sub_word(w_nw[3]);
            w_nw[5] = w_in[5] ^ w_nw[4];
            w_nw[6] = w_in[6] ^ w_nw[5];
            w_nw[7] = w_in[7] ^ w_nw[6];
        end else begin
            w_nw[0] = w_in[0] ^ sub_word(rot_word(w_in[3])) ^ {w_rcon, 24'h0};
            w_nw[1] = w_in[1] ^ w_nw[0];
            w_nw[2] = w_in[2] ^ w_nw[1];
            w_nw[3] = w_in[3] ^ w_nw[2];
        end
    end

    assign o_key = {w_nw[0], w_nw[1], w_nw[2], w_nw[3], w_nw[4], w_nw[5], w_nw[6], w_nw[7]};

endmodule

module aes256_key_sched_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic         busy,
    output logic         key_valid,
    output logic         rd_valid,
    output logic [127:0] rd_key,
    output logic         rd_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    logic [255:0] r_work;
    logic [2:0]   r_s;
    logic [127:0] r_buf [0:14];
    logic         r_key_valid;
    logic         r_rd_valid;
    logic         r_rd_err;
    logic [127:0] r_rd_key;

    logic [255:0] w_exp_out;
    logic         w_busy;
    logic         w_start_acc;
    logic         w_step_en;
    logic         w_last;
    logic         w_rd_ok;
    logic         w_rd_bad;
    logic [127:0] w_rd_data;

    Key_Expansion_new u_key_exp (
        .i_algorithm (2'b10),
        .i_step      (r_s),
        .i_key       (r_work),
        .o_key       (w_exp_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_EXPAND;
            ST_EXPAND: if (r_s == 3'd7) w_next_state = ST_DONE;
            ST_DONE:   if (start) w_next_state = ST_EXPAND;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy      = (r_state == ST_EXPAND);
        w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_step_en   = (r_state == ST_EXPAND);
        w_last      = (r_state == ST_EXPAND) && (r_s == 3'd7);
    end

    // Work register, step counter and key_valid flag.
    // s holds at 7 on the final step so it never wraps while expanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work      <= '0;
            r_s         <= '0;
            r_key_valid <= 1'b0;
        end else if (w_start_acc) begin
            r_work      <= key;
            r_s         <= 3'd1;
            r_key_valid <= 1'b0;
        end else if (w_step_en) begin
            r_work <= w_exp_out;
            if (w_last) begin
                r_key_valid <= 1'b1;
            end else begin
                r_s <= r_s + 3'd1;
            end
        end
    end

    // Round-key buffer: entries 0/1 come straight from the key, step s fills 2s and 2s+1.
    // The seventh step only produces entry 14; its lower half is not a round key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_start_acc) begin
            r_buf[0] <= key[255:128];
            r_buf[1] <= key[127:0];
        end else if (w_step_en) begin
            r_buf[{r_s, 1'b0}] <= w_exp_out[255:128];
            if (!w_last) begin
                r_buf[{r_s, 1'b1}] <= w_exp_out[127:0];
            end
        end
    end

    // A start accepted on the same edge takes priority and turns the read into an error.
    always_comb begin
        w_rd_ok  = rd_en && r_key_valid && (rd_idx <= 4'd14) && !w_start_acc;
        w_rd_bad = rd_en && !w_rd_ok;
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < 15; i++) begin
            if (rd_idx == 4'(i)) begin
                w_rd_data = r_buf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_key   <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_rd_err   <= w_rd_bad;
            if (w_rd_ok) begin
                r_rd_key <= w_rd_data;
            end
        end
    end

    assign busy      = w_busy;
    assign key_valid = r_key_valid;
    assign rd_valid  = r_rd_valid;
    assign rd_key    = r_rd_key;
    assign rd_err    = r_rd_err;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Testbench for aes256_key_sched_ctrl: directed sequence with random keys against a FIPS-197 key schedule model.
// Latency: drives inputs 1 time unit after each rising edge and samples outputs at the same point.
// Backpressure: none; all waits on the DUT are bounded by cycle budgets.
module tb_aes256_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] key;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic         busy;
    logic         key_valid;
    logic         rd_valid;
    logic [127:0] rd_key;
    logic         rd_err;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_rk [15];
    logic [127:0] last_rd;

    aes256_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .busy      (busy),
        .key_valid (key_valid),
        .rd_valid  (rd_valid),
        .rd_key    (rd_key),
        .rd_err    (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: S-box from GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        if (a != 8'h00) begin
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end else begin
            inv = 8'h00;
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    // Standard word-by-word FIPS-197 expansion for Nk=8, 60 words -> 15 round keys.
    task automatic build_model(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = w[i-1];
            if (i % 8 == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                temp = subw(temp);
            end
            w[i] = w[i-8] ^ temp;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [255:0] k);
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (key_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("key_valid_timeout", key_valid, 1'b1);
    endtask

    task automatic read_idx(input string tag, input int i);
        rd_en  = 1'b1;
        rd_idx = 4'(i);
        tick();
        rd_en  = 1'b0;
        chk({tag, "_vld"}, rd_valid, 1'b1);
        chk({tag, "_err"}, rd_err, 1'b0);
        chk({tag, "_dat"}, rd_key, exp_rk[i]);
        last_rd = exp_rk[i];
    endtask

    task automatic read_all(input string tag);
        // back-to-back reads, one per cycle
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rd_idx = 4'(i);
            tick();
            chk($sformatf("%s_vld%0d", tag, i), rd_valid, 1'b1);
            chk($sformatf("%s_dat%0d", tag, i), rd_key, exp_rk[i]);
            last_rd = exp_rk[i];
        end
        rd_en = 1'b0;
        tick();
        chk({tag, "_vld_drop"}, rd_valid, 1'b0);
    endtask

    task automatic bad_read(input string tag, input int i);
        rd_en  = 1'b1;
        rd_idx = 4'(i);
        tick();
        rd_en  = 1'b0;
        chk({tag, "_err"}, rd_err, 1'b1);
        chk({tag, "_vld"}, rd_valid, 1'b0);
        chk({tag, "_dat"}, rd_key, last_rd);
        tick();
        chk({tag, "_err_pulse"}, rd_err, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] k_fips;
        logic [255:0] k1;
        logic [255:0] k2;
        int busy_cnt;

        rst_n = 1'b0; start = 1'b0; key = '0; rd_en = 1'b0; rd_idx = '0;
        last_rd = '0;
        k_fips = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

        // reset state
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_kv", key_valid, 1'b0);
        chk("rst_rdv", rd_valid, 1'b0);
        chk("rst_rderr", rd_err, 1'b0);
        chk("rst_rdkey", rd_key, '0);
        #4 rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_rst", {busy, key_valid}, '0);

        // FIPS-197 vector: latency, busy length, full read-back
        build_model(k_fips);
        chk("model_rk2", exp_rk[2], 128'ha573c29fa176c498a97fce93a572c09c);
        chk("model_rk14", exp_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        start_key(k_fips);
        chk("fips_busy1", busy, 1'b1);
        chk("fips_kv1", key_valid, 1'b0);
        busy_cnt = 1;
        for (int e = 2; e <= 8; e++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            chk($sformatf("fips_kv_edge%0d", e), key_valid, 1'(e == 8));
        end
        chk("fips_busy_cycles", 128'(busy_cnt), 128'd7);
        chk("fips_busy_done", busy, 1'b0);
        read_all("fips");
        chk("fips_lit0", exp_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
        chk("fips_lit1", exp_rk[1], 128'h101112131415161718191a1b1c1d1e1f);

        // out-of-range index while valid
        bad_read("idx15", 15);

        // random key; start with another key and a read mid-expansion are both ignored
        k1 = rand256();
        k2 = rand256();
        build_model(k1);
        start_key(k1);
        tick(); tick();
        key = k2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_start_busy", busy, 1'b1);
        bad_read("rd_in_expand", 3);
        wait_valid();
        read_all("rnd1");

        // start in DONE with zero key, racing a read: start wins
        build_model('0);
        key = '0; start = 1'b1; rd_en = 1'b1; rd_idx = 4'd0;
        tick();
        start = 1'b0; rd_en = 1'b0;
        chk("zero_kv_drop", key_valid, 1'b0);
        chk("zero_busy", busy, 1'b1);
        chk("race_err", rd_err, 1'b1);
        chk("race_vld", rd_valid, 1'b0);
        chk("race_dat", rd_key, last_rd);
        for (int e = 2; e <= 8; e++) begin
            tick();
            chk($sformatf("zero_kv_edge%0d", e), key_valid, 1'(e == 8));
        end
        read_idx("zero_rk2", 2);
        chk("zero_rk2_lit", rd_key, 128'h62636363626363636263636362636363);

        // reset during expansion
        build_model(rand256());
        start_key(rand256());
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_kv", key_valid, 1'b0);
        chk("arst_rdkey", rd_key, '0);
        last_rd = '0;
        tick();
        #3 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("post_rst_idle%0d", c), {busy, key_valid}, '0);
        end
        bad_read("rd_after_rst", 0);

        // a few more random keys with random reads
        for (int t = 0; t < 3; t++) begin
            k1 = rand256();
            build_model(k1);
            start_key(k1);
            wait_valid();
            for (int r = 0; r < 5; r++) begin
                read_idx($sformatf("rk%0d_%0d", t, r), int'($urandom_range(0, 14)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes256_key_sched_ctrl.md
AES256_KEY_SCHED_CTRL -- requirements
Module: aes256_key_sched_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to expand the key; sampled only in IDLE or DONE.
- key  input  256  AES-256 cipher key, sampled on the accepted start edge.
- rd_en  input  1  round-key read request.
- rd_idx  input  4  round-key index, valid range 0..14.
- busy  output  1  high while expansion is in progress.
- key_valid  output  1  high when all 15 round keys are stored and readable.
- rd_valid  output  1  one-cycle pulse, one cycle after a read request.
- rd_key  output  128  registered round-key data.
- rd_err  output  1  one-cycle pulse for a bad read.

Function
REQ-002 The module SHALL instantiate exactly one Key_Expansion_new, driven with Algorithm=2'b10, and time-share it across 7 expansion steps.
REQ-003 Each step SHALL apply the instance's step input to a 256-bit work register and a 3-bit step counter s (1..7).
REQ-004 The module SHALL hold a 15x128 round-key buffer; entry 0 is key[255:128] and entry 1 is key[127:0].
REQ-005 The FSM SHALL have exactly three states: IDLE, EXPAND and DONE.
REQ-006 In IDLE or DONE, start=1 SHALL, on that edge:
- load key into the work register and into buffer entries 0 and 1;
- set s=1;
- go to EXPAND;
- clear key_valid.
REQ-007 In EXPAND, each edge SHALL write the expansion output into the buffer:
- s=1..6: upper 128 bits to entry 2s, lower 128 bits to entry 2s+1;
- s=7: upper 128 bits to entry 14 only.
REQ-008 In EXPAND, each edge SHALL also load the expansion output into the work register and increment s.
REQ-009 The edge that processes s=7 SHALL move the FSM to DONE and set key_valid=1.
REQ-010 Latency SHALL be exactly 8 rising edges from the accepted start edge until key_valid is high.
REQ-011 busy SHALL equal (state==EXPAND).
REQ-012 In EXPAND, start SHALL be ignored; the key in progress is not disturbed.
REQ-013 In DONE, start SHALL restart expansion, and key_valid SHALL drop on that same edge.
REQ-014 A read request SHALL be accepted only when rd_en=1, key_valid=1 and rd_idx<=14:
- on the next edge, rd_key takes the buffer entry at rd_idx;
- rd_valid pulses for one cycle.
REQ-015 A read request with rd_en=1 and either key_valid=0 or rd_idx>=15 SHALL:
- pulse rd_err for one cycle;
- leave rd_key unchanged;
- hold rd_valid at 0.
REQ-016 Reads SHALL be accepted every cycle (back-to-back) with one-cycle latency each.
REQ-017 If rd_en and an accepted start share an edge, start SHALL win and the read SHALL be rejected with rd_err.
REQ-018 The step count SHALL stay in the 3-bit counter s; s SHALL NOT wrap beyond 7 while in EXPAND.

Reset
REQ-019 When rst_n=0, the module SHALL asynchronously force:
- state=IDLE, s=0;
- busy=0, key_valid=0, rd_valid=0, rd_err=0;
- rd_key=0;
- every buffer entry and the work register to 0.
REQ-020 A reset asserted during EXPAND SHALL abort the expansion; after release, the FSM SHALL wait in IDLE for a new start.
REQ-021 Release of rst_n SHALL NOT start an expansion by itself.

Verification
REQ-022 Key 000102...1e1f, start pulsed once, then read all 15 entries SHALL give:
- key_valid high 8 edges after start; busy high for exactly 7 cycles;
- rd_key[0]=000102030405060708090a0b0c0d0e0f;
- rd_key[1]=101112131415161718191a1b1c1d1e1f;
- rd_key[2]=a573c29fa176c498a97fce93a572c09c;
- rd_key[14]=24fc79ccbf0979e9371ac23c6d68de36.
REQ-023 rd_en=1 with rd_idx=15 while key_valid=1, and rd_en=1 with rd_idx=3 during EXPAND, SHALL each give a one-cycle rd_err pulse, rd_valid=0 and rd_key unchanged.
REQ-024 Start pulsed again with a different key on cycle 3 of EXPAND SHALL be ignored; the final buffer SHALL match the first key's FIPS-197 schedule.
REQ-025 rst_n driven low on cycle 4 of EXPAND SHALL immediately clear busy, key_valid and rd_key; after release with no start, the FSM SHALL stay in IDLE for 20 cycles.
REQ-026 A start in DONE with an all-zero key SHALL drop key_valid on that edge; after 8 edges, entry 2 SHALL read 62636363626363636263636362636363.
